// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register: single outstanding imem request, one-entry hold buffer.
// Optional macro FETCH_NOP_BUBBLE_EN: instr_o reads as ADDI x0,x0,0 whenever the slot is invalid.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        instr_valid_o
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        kill_q, kill_d;
  logic        valid_q, valid_d;
  logic        ifid_free;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    buf_d     = buf_q;
    buf_pc_d  = buf_pc_q;
    instr_d   = instr_q;
    ifid_pc_d = ifid_pc_q;
    kill_d    = kill_q;
    // A stalled live slot holds; otherwise the slot drains to a bubble.
    valid_d   = valid_q & stall_i;
    ifid_free = ~valid_q | ~stall_i;

    case (state_q)
      FETCH: begin
        if (imem_gnt_i) begin
          req_pc_d = pc_q;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = FETCH;
          end else begin
            pc_d = req_pc_q + 32'd4;
            if (ifid_free) begin
              instr_d   = imem_rdata_i;
              ifid_pc_d = req_pc_q;
              valid_d   = 1'b1;
              state_d   = FETCH;
            end else begin
              buf_d    = imem_rdata_i;
              buf_pc_d = req_pc_q;
              state_d  = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (!stall_i) begin
          instr_d   = buf_q;
          ifid_pc_d = buf_pc_q;
          valid_d   = 1'b1;
          state_d   = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    // Redirect beats stall; a response already in flight is marked for discard.
    if (redirect_i) begin
      pc_d      = align_pc(redirect_pc_i);
      valid_d   = 1'b0;
      instr_d   = instr_q;
      ifid_pc_d = ifid_pc_q;
      case (state_q)
        FETCH: begin
          if (imem_gnt_i) kill_d = 1'b1;
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            kill_d  = 1'b0;
            state_d = FETCH;
          end else begin
            kill_d  = 1'b1;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FETCH;
      pc_q      <= align_pc(RESET_PC);
      req_pc_q  <= 32'd0;
      buf_q     <= 32'd0;
      buf_pc_q  <= 32'd0;
      instr_q   <= 32'd0;
      ifid_pc_q <= 32'd0;
      kill_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      buf_q     <= buf_d;
      buf_pc_q  <= buf_pc_d;
      instr_q   <= instr_d;
      ifid_pc_q <= ifid_pc_d;
      kill_q    <= kill_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_req_o    = rst_ni & (state_q == FETCH);
  assign imem_addr_o   = pc_q;
  assign pc_o          = ifid_pc_q;
  assign pc_plus4_o    = ifid_pc_q + 32'd4;
  assign instr_valid_o = valid_q;

`ifdef FETCH_NOP_BUBBLE_EN
  assign instr_o = valid_q ? instr_q : 32'h0000_0013;
`else
  assign instr_o = instr_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage and IF/ID pipeline register, directly upstream of the control/decode block.
- Holds the PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers one returned word while decode is stalled.
- Presents instruction, PC and valid to decode; handles branch/jump redirects by flushing.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] ignored.

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- stall_i  input  1  decode stall; IF/ID holds its contents
- redirect_i  input  1  taken branch/jump from downstream; flush and load new PC
- redirect_pc_i  input  32  redirect target
- imem_req_o  output  1  fetch request
- imem_addr_o  output  32  fetch address, bits [1:0] always 0
- imem_gnt_i  input  1  request accepted this cycle
- imem_rvalid_i  input  1  read data valid; earliest one cycle after gnt
- imem_rdata_i  input  32  instruction word
- instr_o  output  32  IF/ID instruction, feeds decode instruction_i
- pc_o  output  32  PC of instr_o
- pc_plus4_o  output  32  pc_o + 4, for JAL/JALR link
- instr_valid_o  output  1  IF/ID slot holds a live instruction

Behaviour:
- Single outstanding request. Internal regs:
  - pc_q: next fetch PC
  - req_pc_q: PC of the outstanding request
  - kill_q: outstanding response is to be discarded
  - buf_q / buf_pc_q: one-entry hold buffer
  - state: FETCH, WAIT, HOLD
- Reset (rst_ni low, asynchronous):
  - pc_q=RESET_PC & ~3, state=FETCH, kill_q=0, instr_valid_o=0, pc_o=0.
  - instr_o reset value is defined under Optional Feature.
  - imem_req_o=0 while rst_ni low.
  - Reset mid-request abandons it; a late rvalid in FETCH is ignored.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc_q.
  - On gnt: req_pc_q<=pc_q, go to WAIT.
  - No gnt: hold request and address stable.
- WAIT:
  - imem_req_o=0.
  - On rvalid with kill_q=1: discard, kill_q<=0, go to FETCH.
  - On rvalid with kill_q=0 and IF/ID free (instr_valid_o=0 or stall_i=0): load IF/ID {rdata, req_pc_q}, instr_valid_o<=1, pc_q<=req_pc_q+4, go to FETCH.
  - On rvalid with kill_q=0 and IF/ID busy (valid and stall_i=1): latch into buf, pc_q<=req_pc_q+4, go to HOLD.
- HOLD:
  - imem_req_o=0.
  - When stall_i=0: IF/ID<=buf, go to FETCH.
- IF/ID with stall_i=1 and instr_valid_o=1: holds all outputs.
- IF/ID with stall_i=0 and no new word: instr_valid_o<=0 (bubble).
- Throughput: one instruction per 2 cycles with zero-wait memory.
- Redirect (highest priority, overrides stall):
  - pc_q<=redirect_pc_i & ~3, instr_valid_o<=0, buf dropped.
  - FETCH without gnt: next cycle requests new PC.
  - FETCH with gnt in the same cycle: go to WAIT with kill_q<=1.
  - WAIT: kill_q<=1, stay in WAIT; a same-cycle rvalid is discarded and state goes to FETCH.
  - HOLD: go to FETCH.
- Arithmetic: PC +4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

Optional Feature:
- Macro FETCH_NOP_BUBBLE_EN.
- Defined: whenever instr_valid_o=0 (reset, flush, bubble), instr_o=32'h0000_0013 (ADDI x0,x0,0). Decode may ignore instr_valid_o.
- Undefined: instr_o resets to 0 and retains its last value when invalid. Consumers must qualify with instr_valid_o.

Test Plan:
- Reset release, memory returns 32'h00500093 at 0x0 and 32'h00A00113 at 0x4, zero wait -> addr sequence 0x0, 0x4, 0x8.
  - instr_o/pc_o = 00500093/0x0, then 00A00113/0x4.
  - instr_valid_o pulses every 2nd cycle.
- Hold gnt low 3 cycles -> imem_req_o and imem_addr_o=0x4 stable all 3 cycles; no PC advance.
- stall_i=1 with valid IF/ID at pc 0x8, response 0x13 for 0xC arrives -> IF/ID holds 0x8; state HOLD; no new request. After stall_i drops: pc_o=0xC next cycle, then request 0x10.
- redirect_i with redirect_pc_i=0x100 while in WAIT for 0x10 -> late rvalid discarded; instr_valid_o=0; next request addr 0x100.
- redirect_i to 0x203 coincident with gnt in FETCH -> that response is dropped; next addr 0x200.
- Assert rst_ni low mid-WAIT -> outputs reset immediately without a clock edge; first request after release is RESET_PC. With FETCH_NOP_BUBBLE_EN defined, instr_o=0x00000013 during reset.
